armleocpu_muldiv: RTL and testbench
===================================

// Module: armleocpu_muldiv
// PURPOSE
//  Iterative RV32M multiply/divide unit beside the integer ALU in the execute stage.
//  Executes the OP-class encodings with funct7=0000001, which the ALU flags illegal.
//  Execute routes those encodings here and stalls until the result handshake completes.
//  Writeback takes res_result.
// PARAMETERS
//  none; datapath fixed at 32 bits, 32 iterations for multiply and divide.
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   asynchronous reset, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   unit idle, can accept
//  req_funct3  in   3   000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_rs1     in   32  operand A (multiplicand / dividend)
//  req_rs2     in   32  operand B (multiplier / divisor)
//  kill        in   1   abort in-flight op (pipeline flush)
//  res_valid   out  1   result available
//  res_ready   in   1   consumer takes result
//  res_result  out  32  result
//  busy        out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async, any time incl. mid-op): state=IDLE, req_ready=1, res_valid=0, res_result=0, busy=0, counter=0.
//  States: IDLE -> MUL | DIV -> DONE -> IDLE.
//  Accept: req_valid&req_ready&!kill in cycle T. Latch funct3 and operands. Later input changes are ignored.
//  Signed ops compute on magnitudes:
//   - signed operands are abs()'d at accept (MULHSU: rs1 signed, rs2 unsigned)
//   - product is negated if exactly one signed operand was negative
//   - quotient is negated if the signs differ
//   - remainder takes the dividend's sign
//  MUL state: radix-2 shift-add on a 64-bit accumulator, 32 iterations, 5-bit counter.
//   MUL returns low word; MULH/MULHSU/MULHU return high word.
//  DIV state: restoring, 1 quotient bit per cycle, 32 iterations, 33-bit partial remainder.
//  Normal latency: res_valid rises at T+33; DONE is entered after the last iteration.
//  Special cases bypass iteration and enter DONE at T+1:
//   - divisor==0: DIV/DIVU=0xFFFFFFFF; REM/REMU=rs1
//   - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV=0x80000000, REM=0
//  DONE: res_valid=1, res_result stable until res_valid&res_ready.
//   On that cycle go IDLE; req_ready=1 next cycle (no same-cycle re-accept).
//  res_valid/res_result are registered outputs. res_result holds its last value in IDLE.
//  kill, any state: next cycle IDLE, res_valid=0, in-flight result discarded.
//   kill beats req_valid in the same cycle (no accept).
//   kill beats res_ready in DONE (result dropped).
//  req_ready=1 only in IDLE. busy = !IDLE.
//  Wrap-around: iteration counter counts 31 down to 0; exit on 0, never wraps.
// CONFIGURATION
//  ARMLEOCPU_MULDIV_FAST_MUL_EN defined:
//   - MUL* uses a single-cycle 33x33 signed '*' product at accept
//   - MUL state unused; DONE at T+1, res_valid at T+1
//   - divide unchanged
//  Not defined: 32-iteration shift-add multiply as above; no '*' operator synthesized.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; res_valid at T+33 (T+1 with _EN).
//  MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; latency 33.
//  DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//   All three at T+1.
//  DIVU 100/7: hold res_ready=0 for 5 cycles after res_valid.
//   -> res_result=14 stable, req_ready=0 throughout, req_ready=1 cycle after handshake.
//  Kill/reset mid-op:
//   - kill at T+10 of DIV -> res_valid never asserts, req_ready=1 at T+11
//   - rst pulse mid-MUL -> all outputs at reset values immediately

Source files
------------

// File: rtl/armleocpu_muldiv.sv
// armleocpu_muldiv
//   Iterative RV32M multiply/divide unit for the execute stage. A request is
//   accepted in IDLE, iterated in MUL or DIV (one bit per cycle, 32 cycles),
//   and the result is held in DONE until the consumer takes it.
//   Divide by zero and signed overflow skip iteration and go to DONE at once.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active-high
//   req_valid   request present
//   req_ready   unit idle, can accept
//   req_funct3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//               100 DIV, 101 DIVU, 110 REM, 111 REMU
//   req_rs1     operand A (multiplicand / dividend)
//   req_rs2     operand B (multiplier / divisor)
//   kill        abort any in-flight operation (pipeline flush)
//   res_valid   result available (registered)
//   res_ready   consumer takes result
//   res_result  result (registered, holds last value while idle)
//   busy        high in any state except IDLE
//
// Configuration
//   ARMLEOCPU_MULDIV_FAST_MUL_EN : when defined, all multiplies use a
//   single-cycle signed product at accept and finish one cycle later.
//   When undefined, multiplies use the 32-cycle shift-add datapath and
//   no '*' operator is present.

module armleocpu_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Two's complement negate helpers
  function automatic logic [31:0] cond_neg32(input logic neg, input logic [31:0] x);
    return neg ? (~x + 32'd1) : x;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic neg, input logic [63:0] x);
    return neg ? (~x + 64'd1) : x;
  endfunction

  // Request decode (valid only while accepting in IDLE)
  logic        is_div;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        res_neg;
  logic        div_zero;
  logic        div_ovf;
  logic        special;
  logic [31:0] special_result;
  logic        accept;

  always_comb begin
    is_div   = req_funct3[2];
    a_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
               (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
    b_signed = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
               (req_funct3 == 3'b110);
    a_neg    = a_signed & req_rs1[31];
    b_neg    = b_signed & req_rs2[31];
    a_mag    = cond_neg32(a_neg, req_rs1);
    b_mag    = cond_neg32(b_neg, req_rs2);
    // Remainder follows the dividend; product and quotient follow sign mismatch
    if (is_div && req_funct3[1]) begin
      res_neg = a_neg;
    end else begin
      res_neg = a_neg ^ b_neg;
    end
    div_zero = is_div && (req_rs2 == 32'd0);
    div_ovf  = is_div && !req_funct3[0] &&
               (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) begin
      special_result = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else begin
      special_result = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

`ifdef ARMLEOCPU_MULDIV_FAST_MUL_EN
  // 33x33 signed product: each operand is extended by its own signedness,
  // then the product is kept to the 64 bits that any MUL* variant can need.
  logic signed [63:0] fast_a;
  logic signed [63:0] fast_b;
  logic signed [63:0] fast_prod;
  logic        [31:0] fast_result;

  always_comb begin
    fast_a      = {{32{a_signed & req_rs1[31]}}, req_rs1};
    fast_b      = {{32{b_signed & req_rs2[31]}}, req_rs2};
    fast_prod   = fast_a * fast_b;
    fast_result = (req_funct3[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif

  // Latched operation and datapath state
  logic [2:0]  op_funct3;
  logic        op_neg;
  logic [31:0] mcand;
  logic [63:0] acc;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [4:0]  counter;

  // Shift-add step: add multiplicand into upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [32:0] mul_sum;
  logic [63:0] acc_next;
  logic [63:0] mul_full;
  logic [31:0] mul_final;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    acc_next  = {mul_sum, acc[31:1]};
    mul_full  = cond_neg64(op_neg, acc_next);
    mul_final = (op_funct3[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
  end

  // Restoring divide step on a 33-bit trial remainder. Only the low 32 bits
  // of the difference are kept: after a successful subtract it is < divisor.
  logic [32:0] trial;
  logic        trial_ge;
  logic [31:0] trial_diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] div_final;

  always_comb begin
    trial      = {rem, quo[31]};
    trial_ge   = (trial >= {1'b0, divisor});
    trial_diff = trial[31:0] - divisor;
    rem_next   = trial_ge ? trial_diff : trial[31:0];
    quo_next   = {quo[30:0], trial_ge};
    div_final  = op_funct3[1] ? cond_neg32(op_neg, rem_next)
                              : cond_neg32(op_neg, quo_next);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; kill wins over both a new request and a result handshake
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !kill) begin
          accept = 1'b1;
          if (special) begin
            state_next = DONE;
          end else if (is_div) begin
            state_next = DIV;
          end else begin
`ifdef ARMLEOCPU_MULDIV_FAST_MUL_EN
            state_next = DONE;
`else
            state_next = MUL;
`endif
          end
        end
      end
      MUL, DIV: begin
        if (kill) begin
          state_next = IDLE;
        end else if (counter == 5'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (kill || res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter    <= 5'd0;
      res_valid  <= 1'b0;
      res_result <= 32'd0;
    end else begin
      res_valid <= (state_next == DONE);

      if (accept) begin
        counter <= 5'd31;
      end else if (kill) begin
        counter <= 5'd0;
      end else if (((state == MUL) || (state == DIV)) && (counter != 5'd0)) begin
        counter <= counter - 5'd1;
      end

      if (accept && special) begin
        res_result <= special_result;
`ifdef ARMLEOCPU_MULDIV_FAST_MUL_EN
      end else if (accept && !is_div) begin
        res_result <= fast_result;
`endif
      end else if ((state == MUL) && !kill && (counter == 5'd0)) begin
        res_result <= mul_final;
      end else if ((state == DIV) && !kill && (counter == 5'd0)) begin
        res_result <= div_final;
      end
    end
  end

  // Datapath registers (no reset: only meaningful after an accept)
  always_ff @(posedge clk) begin
    if (accept) begin
      op_funct3 <= req_funct3;
      op_neg    <= res_neg;
      mcand     <= a_mag;
      acc       <= {32'd0, b_mag};
      divisor   <= b_mag;
      rem       <= 32'd0;
      quo       <= a_mag;
    end else if (state == MUL) begin
      acc <= acc_next;
    end else if (state == DIV) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

endmodule

// File: tb/tb_armleocpu_muldiv.sv
// Directed bench for armleocpu_muldiv: reset values, each MUL*/DIV* class,
// divide special cases, result back-pressure, kill and mid-operation reset.
module tb_armleocpu_muldiv;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        kill;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_result;
  logic        busy;

  int vectors;
  int miscompares;
  int lat;
  int saw_valid;

`ifdef ARMLEOCPU_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  armleocpu_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .kill       (kill),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_result (res_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble the inputs after accept, wait for the
  // result, check value and latency, then hand it off.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res_result, exp);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, "_rdy_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_vld_after"}, {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_funct3  = 3'd0;
    req_rs1     = 32'd0;
    req_rs2     = 32'd0;
    kill        = 1'b0;
    res_ready   = 1'b0;
    vectors     = 0;
    miscompares = 0;

    #12;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_res_result", res_result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_LAT);
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    run_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // DIVU 100/7 with the consumer stalling for five cycles
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'b101;
    req_rs1    = 32'd100;
    req_rs2    = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_lat", lat, DIV_LAT);
    check("hold_res", res_result, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_vld", {31'd0, res_valid}, 32'd1);
      check("hold_res_stable", res_result, 32'd14);
      check("hold_rdy_low", {31'd0, req_ready}, 32'd0);
    end
    // Handshake with a new request already waiting: it must not be taken
    res_ready  = 1'b1;
    req_valid  = 1'b1;
    req_funct3 = 3'b000;
    req_rs1    = 32'd3;
    req_rs2    = 32'd3;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    req_valid = 1'b0;
    check("hs_no_reaccept", {31'd0, busy}, 32'd0);
    check("hs_rdy", {31'd0, req_ready}, 32'd1);
    check("hs_vld", {31'd0, res_valid}, 32'd0);
    check("hs_res_held", res_result, 32'd14);

    // kill in the same cycle as a request: nothing accepted
    @(negedge clk);
    req_valid  = 1'b1;
    kill       = 1'b1;
    req_funct3 = 3'b100;
    req_rs1    = 32'd50;
    req_rs2    = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    kill      = 1'b0;
    check("kill_vs_req_busy", {31'd0, busy}, 32'd0);

    // kill during DIV at T+10
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'b100;
    req_rs1    = 32'd50;
    req_rs2    = 32'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("kill_busy_before", {31'd0, busy}, 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_rdy", {31'd0, req_ready}, 32'd1);
    check("kill_vld", {31'd0, res_valid}, 32'd0);
    saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) saw_valid = 1;
    end
    check("kill_never_valid", saw_valid, 32'd0);

    // kill beats res_ready in DONE
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'b111;
    req_rs1    = 32'd9;
    req_rs2    = 32'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("killdone_vld", {31'd0, res_valid}, 32'd1);
    kill      = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    kill      = 1'b0;
    res_ready = 1'b0;
    check("killdone_vld_after", {31'd0, res_valid}, 32'd0);
    check("killdone_rdy", {31'd0, req_ready}, 32'd1);

    // asynchronous reset pulse in the middle of a MUL
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = 3'b000;
    req_rs1    = 32'd7;
    req_rs2    = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_rdy", {31'd0, req_ready}, 32'd1);
    check("rst_mid_vld", {31'd0, res_valid}, 32'd0);
    check("rst_mid_res", res_result, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_post_rst", 3'b000, 32'd7, 32'd3, 32'd21, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
